// File: rtl/mic_pkg.sv
// Shared types and widths for the MEMS microphone clock controller.
// No logic; widths and state encoding only.
// No flow control.
package mic_pkg;

    localparam int MIC_DIV_W  = 8;
    localparam int MIC_WAKE_W = 16;

    typedef enum logic [1:0] {
        ST_OFF  = 2'd0,
        ST_WAKE = 2'd1,
        ST_RUN  = 2'd2,
        ST_STOP = 2'd3
    } mic_state_e;

endpackage

// File: rtl/mic_clk_div.sv
// Programmable microphone clock divider: half-period = div_cur+1 clk cycles.
// micclk is registered; rise_evt/fall_evt flag the toggle that happens on the next edge.
// No backpressure; run gates counting, clr forces count and micclk to 0.
module mic_clk_div
    import mic_pkg::*;
#(
    parameter logic [MIC_DIV_W-1:0] DIV_RESET = 8'h03
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 run,
    input  logic                 clr,
    input  logic                 div_load,
    input  logic [MIC_DIV_W-1:0] div_val,
    output logic                 micclk,
    output logic                 rise_evt,
    output logic                 fall_evt,
    output logic [MIC_DIV_W-1:0] div_cur
);

    logic [MIC_DIV_W-1:0] count_q, count_d;
    logic [MIC_DIV_W-1:0] div_q, div_d;
    logic                 micclk_q, micclk_d;
    logic                 hit;

    assign hit      = run && (count_q == div_q);
    assign rise_evt = hit && !micclk_q;
    assign fall_evt = hit && micclk_q;

    // Next count/toggle; a clear wins over a pending toggle so no runt pulse escapes.
    always_comb begin
        count_d  = count_q;
        micclk_d = micclk_q;
        div_d    = div_q;
        if (div_load) begin
            div_d = div_val;
        end
        if (clr) begin
            count_d  = '0;
            micclk_d = 1'b0;
        end else if (hit) begin
            count_d  = '0;
            micclk_d = !micclk_q;
        end else if (run) begin
            count_d = count_q + MIC_DIV_W'(1);
        end
    end

    // Divider state registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            count_q  <= '0;
            micclk_q <= 1'b0;
            div_q    <= DIV_RESET;
        end else begin
            count_q  <= count_d;
            micclk_q <= micclk_d;
            div_q    <= div_d;
        end
    end

    assign micclk  = micclk_q;
    assign div_cur = div_q;

endmodule

// File: rtl/mic_clk_ctrl.sv
// Microphone clock sequencer: OFF -> WAKE -> RUN -> clean stop, with per-edge capture strobes.
// Strobes/data_valid are registered alongside micclk (same cycle as the new micclk level).
// No backpressure; divider writes outside OFF are held until the next falling toggle.
module mic_clk_ctrl
    import mic_pkg::*;
#(
    parameter logic [MIC_DIV_W-1:0] DIV_RESET   = 8'h03,
    parameter int unsigned          WAKE_CYCLES = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 en,
    input  logic                 div_wr,
    input  logic [MIC_DIV_W-1:0] div_wdata,
    output logic                 micclk,
    output logic                 rise_stb,
    output logic                 fall_stb,
    output logic                 data_valid,
    output logic [MIC_DIV_W-1:0] div_cur,
    output logic                 div_pend
);

    localparam logic [MIC_WAKE_W-1:0] WAKE_TGT = MIC_WAKE_W'(WAKE_CYCLES);

    mic_state_e             state_q, state_d;
    logic [MIC_WAKE_W-1:0]  wake_q, wake_d, wake_inc;
    logic                   pend_q, pend_d;
    logic [MIC_DIV_W-1:0]   pend_val_q, pend_val_d;
    logic                   rise_stb_q, rise_stb_d;
    logic                   fall_stb_q, fall_stb_d;
    logic                   dv_q, dv_d;

    logic                   run, clr, div_load;
    logic [MIC_DIV_W-1:0]   div_val;
    logic                   rise_evt, fall_evt, micclk_w;
    logic [MIC_DIV_W-1:0]   div_cur_w;

    assign wake_inc = wake_q + MIC_WAKE_W'(1);
    assign run      = (state_q != ST_OFF);
    assign clr      = (state_d == ST_OFF);

    // Sequencer next state and wake counting.
    always_comb begin
        state_d = state_q;
        wake_d  = wake_q;
        case (state_q)
            ST_OFF: begin
                if (en) begin
                    state_d = ST_WAKE;
                    wake_d  = '0;
                end
            end
            ST_WAKE, ST_RUN: begin
                if (!en) begin
                    // Low phase: stop now. High phase: finish it, unless it ends this edge.
                    if (!micclk_w || fall_evt) begin
                        state_d = ST_OFF;
                    end else begin
                        state_d = ST_STOP;
                    end
                end else if (state_q == ST_WAKE && rise_evt) begin
                    wake_d = wake_inc;
                    if (wake_inc == WAKE_TGT) begin
                        state_d = ST_RUN;
                    end
                end
            end
            ST_STOP: begin
                if (fall_evt) begin
                    state_d = ST_OFF;
                end
            end
            default: state_d = ST_OFF;
        endcase
    end

    // Divider write path: direct in OFF, otherwise deferred to a falling toggle.
    // Entering OFF also counts as a boundary so a pending value is never stranded.
    always_comb begin
        pend_d     = pend_q;
        pend_val_d = pend_val_q;
        div_load   = 1'b0;
        div_val    = div_wdata;
        if (state_q == ST_OFF) begin
            div_load = div_wr;
        end else if (div_wr && (fall_evt || clr)) begin
            div_load = 1'b1;
            pend_d   = 1'b0;
        end else if (div_wr) begin
            pend_d     = 1'b1;
            pend_val_d = div_wdata;
        end else if (pend_q && (fall_evt || clr)) begin
            div_load = 1'b1;
            div_val  = pend_val_q;
            pend_d   = 1'b0;
        end
    end

    // Strobes only for toggles taken while in RUN; a rise cancelled by stop is not reported.
    always_comb begin
        rise_stb_d = (state_q == ST_RUN) && rise_evt && !clr;
        fall_stb_d = (state_q == ST_RUN) && fall_evt;
        dv_d       = (state_d == ST_RUN);
    end

    // Control registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_OFF;
            wake_q     <= '0;
            pend_q     <= 1'b0;
            pend_val_q <= '0;
            rise_stb_q <= 1'b0;
            fall_stb_q <= 1'b0;
            dv_q       <= 1'b0;
        end else begin
            state_q    <= state_d;
            wake_q     <= wake_d;
            pend_q     <= pend_d;
            pend_val_q <= pend_val_d;
            rise_stb_q <= rise_stb_d;
            fall_stb_q <= fall_stb_d;
            dv_q       <= dv_d;
        end
    end

    mic_clk_div #(
        .DIV_RESET (DIV_RESET)
    ) u_div (
        .clk      (clk),
        .rst      (rst),
        .run      (run),
        .clr      (clr),
        .div_load (div_load),
        .div_val  (div_val),
        .micclk   (micclk_w),
        .rise_evt (rise_evt),
        .fall_evt (fall_evt),
        .div_cur  (div_cur_w)
    );

    assign micclk     = micclk_w;
    assign rise_stb   = rise_stb_q;
    assign fall_stb   = fall_stb_q;
    assign data_valid = dv_q;
    assign div_cur    = div_cur_w;
    assign div_pend   = pend_q;

endmodule

// File: tb/tb_mic_clk_ctrl.sv
// Directed bench for mic_clk_ctrl with DIV_RESET=3, WAKE_CYCLES=4.
// Outputs are sampled 1 time unit after each rising clk edge; inputs change there too.
// Scenarios run back to back; each relies on the state the previous one left.
module tb_mic_clk_ctrl;

    logic       clk;
    logic       rst;
    logic       en;
    logic       div_wr;
    logic [7:0] div_wdata;
    logic       micclk;
    logic       rise_stb;
    logic       fall_stb;
    logic       data_valid;
    logic [7:0] div_cur;
    logic       div_pend;

    int checks = 0;
    int errors = 0;

    mic_clk_ctrl #(
        .DIV_RESET   (8'h03),
        .WAKE_CYCLES (4)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .en         (en),
        .div_wr     (div_wr),
        .div_wdata  (div_wdata),
        .micclk     (micclk),
        .rise_stb   (rise_stb),
        .fall_stb   (fall_stb),
        .data_valid (data_valid),
        .div_cur    (div_cur),
        .div_pend   (div_pend)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reset values, held and after release with en=0.
    task automatic test_reset();
        logic [12:0] obs;
        rst = 1'b1; en = 1'b0; div_wr = 1'b0; div_wdata = 8'h00;
        tick(); tick();
        obs = {micclk, rise_stb, fall_stb, data_valid, div_pend, div_cur};
        checks++;
        if (obs !== {5'b00000, 8'h03}) begin
            errors++;
            $display("FAIL reset_hold got=%h want=%h", obs, {5'b00000, 8'h03});
        end
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            obs = {micclk, rise_stb, fall_stb, data_valid, div_pend, div_cur};
            checks++;
            if (obs !== {5'b00000, 8'h03}) begin
                errors++;
                $display("FAIL reset_idle i=%0d got=%h want=%h", i, obs, {5'b00000, 8'h03});
            end
        end
    endtask

    // Case A: wake with 4 rises, RUN at E+28, strobes from E+32. Leaves state at E+45.
    task automatic test_case_a();
        logic [3:0] obs, exp;
        en = 1'b1;
        tick();
        for (int n = 0; n <= 45; n++) begin
            if (n > 0) tick();
            exp[3] = (n >= 4) && (((n - 4) % 8) < 4);
            exp[2] = (n >= 36) && (((n - 4) % 8) == 0);
            exp[1] = (n >= 32) && (((n - 4) % 8) == 4);
            exp[0] = (n >= 28);
            obs = {micclk, rise_stb, fall_stb, data_valid};
            checks++;
            if (obs !== exp) begin
                errors++;
                $display("FAIL case_a n=%0d {clk,rs,fs,dv} got=%b want=%b", n, obs, exp);
            end
        end
    endtask

    // Divider write mid-high (E+46) pends until the fall at E+48, then period 4.
    // A write coinciding with the fall at E+60 applies directly.
    task automatic test_div_change();
        logic [2:0] obs, exp;
        div_wr = 1'b1; div_wdata = 8'd1;
        tick();                                    // E+46
        div_wr = 1'b0;
        checks++;
        if ({div_pend, micclk, div_cur} !== {2'b11, 8'd3}) begin
            errors++;
            $display("FAIL div_pend_set got pend=%b clk=%b cur=%0d want 1 1 3", div_pend, micclk, div_cur);
        end
        tick();                                    // E+47
        checks++;
        if ({div_pend, micclk} !== 2'b11) begin
            errors++;
            $display("FAIL div_pend_hold got pend=%b clk=%b want 1 1", div_pend, micclk);
        end
        tick();                                    // E+48
        checks++;
        if ({div_pend, micclk, fall_stb, div_cur} !== {3'b001, 8'd1}) begin
            errors++;
            $display("FAIL div_apply got pend=%b clk=%b fs=%b cur=%0d want 0 0 1 1", div_pend, micclk, fall_stb, div_cur);
        end
        for (int k = 49; k <= 59; k++) begin
            tick();
            exp[2] = (k >= 50) && (((k - 50) % 4) < 2);
            exp[1] = (k >= 50) && (((k - 50) % 4) == 0);
            exp[0] = (k >= 52) && (((k - 50) % 4) == 2);
            obs = {micclk, rise_stb, fall_stb};
            checks++;
            if (obs !== exp) begin
                errors++;
                $display("FAIL div_period4 k=%0d {clk,rs,fs} got=%b want=%b", k, obs, exp);
            end
        end
        div_wr = 1'b1; div_wdata = 8'd3;
        tick();                                    // E+60, falling toggle
        div_wr = 1'b0;
        checks++;
        if ({div_pend, micclk, fall_stb, div_cur} !== {3'b001, 8'd3}) begin
            errors++;
            $display("FAIL div_same_edge got pend=%b clk=%b fs=%b cur=%0d want 0 0 1 3", div_pend, micclk, fall_stb, div_cur);
        end
    endtask

    // en drops with 2 of 4 high cycles elapsed: micclk falls 2 cycles later, then stays low.
    task automatic test_stop_high();
        logic [3:0] obs;
        for (int k = 61; k <= 65; k++) tick();    // rise at E+64
        checks++;
        if ({micclk, data_valid} !== 2'b11) begin
            errors++;
            $display("FAIL stop_pre got clk=%b dv=%b want 1 1", micclk, data_valid);
        end
        en = 1'b0;
        tick();                                    // E+66
        checks++;
        if ({micclk, data_valid} !== 2'b10) begin
            errors++;
            $display("FAIL stop_dv_drop got clk=%b dv=%b want 1 0", micclk, data_valid);
        end
        tick();                                    // E+67
        checks++;
        if (micclk !== 1'b1) begin
            errors++;
            $display("FAIL stop_still_high got=%b want=1", micclk);
        end
        for (int k = 68; k <= 76; k++) begin
            tick();
            obs = {micclk, rise_stb, fall_stb, data_valid};
            checks++;
            if (obs !== 4'b0000) begin
                errors++;
                $display("FAIL stop_low k=%0d {clk,rs,fs,dv} got=%b want=0000", k, obs);
            end
        end
    endtask

    // div=0 written in OFF takes effect at once; micclk = clk/2, strobes alternate in RUN.
    task automatic test_clk2();
        logic [3:0] obs, exp;
        div_wr = 1'b1; div_wdata = 8'd0;
        tick();
        div_wr = 1'b0;
        checks++;
        if ({div_pend, div_cur} !== {1'b0, 8'd0}) begin
            errors++;
            $display("FAIL clk2_off_load got pend=%b cur=%0d want 0 0", div_pend, div_cur);
        end
        en = 1'b1;
        tick();
        for (int n = 0; n <= 20; n++) begin
            if (n > 0) tick();
            exp[3] = (n % 2) == 1;
            exp[2] = (n >= 9) && ((n % 2) == 1);
            exp[1] = (n >= 8) && ((n % 2) == 0);
            exp[0] = (n >= 7);
            obs = {micclk, rise_stb, fall_stb, data_valid};
            checks++;
            if (obs !== exp) begin
                errors++;
                $display("FAIL clk2 n=%0d {clk,rs,fs,dv} got=%b want=%b", n, obs, exp);
            end
        end
        // micclk low while a rise is due: stop wins, no rise and no strobe.
        en = 1'b0;
        for (int n = 21; n <= 24; n++) begin
            tick();
            obs = {micclk, rise_stb, fall_stb, data_valid};
            checks++;
            if (obs !== 4'b0000) begin
                errors++;
                $display("FAIL clk2_stop n=%0d {clk,rs,fs,dv} got=%b want=0000", n, obs);
            end
        end
    endtask

    // Wake aborts with micclk low; re-enable must count 4 fresh rises. Leaves RUN at E+30.
    task automatic test_wake_abort();
        logic [3:0] obs, exp;
        div_wr = 1'b1; div_wdata = 8'd3;
        tick();
        div_wr = 1'b0;
        en = 1'b1;
        tick(); tick(); tick();
        en = 1'b0;
        for (int n = 3; n <= 12; n++) begin
            tick();
            obs = {micclk, rise_stb, fall_stb, data_valid};
            checks++;
            if (obs !== 4'b0000) begin
                errors++;
                $display("FAIL wake_pulse n=%0d {clk,rs,fs,dv} got=%b want=0000", n, obs);
            end
        end
        // Second abort after two rises, during the low phase at E+18.
        en = 1'b1;
        tick();
        for (int n = 0; n <= 17; n++) begin
            if (n > 0) tick();
            exp = {((n >= 4) && (((n - 4) % 8) < 4)), 3'b000};
            obs = {micclk, rise_stb, fall_stb, data_valid};
            checks++;
            if (obs !== exp) begin
                errors++;
                $display("FAIL wake_partial n=%0d {clk,rs,fs,dv} got=%b want=%b", n, obs, exp);
            end
        end
        en = 1'b0;
        for (int n = 18; n <= 22; n++) begin
            tick();
            obs = {micclk, rise_stb, fall_stb, data_valid};
            checks++;
            if (obs !== 4'b0000) begin
                errors++;
                $display("FAIL wake_abort n=%0d {clk,rs,fs,dv} got=%b want=0000", n, obs);
            end
        end
        en = 1'b1;
        tick();
        for (int n = 0; n <= 30; n++) begin
            if (n > 0) tick();
            exp[3] = (n >= 4) && (((n - 4) % 8) < 4);
            exp[2] = 1'b0;
            exp[1] = 1'b0;
            exp[0] = (n >= 28);
            obs = {micclk, rise_stb, fall_stb, data_valid};
            checks++;
            if (obs !== exp) begin
                errors++;
                $display("FAIL wake_restart n=%0d {clk,rs,fs,dv} got=%b want=%b", n, obs, exp);
            end
        end
    endtask

    // Pending write at E+31, reset at E+32 (which would have been a fall with fall_stb).
    task automatic test_reset_mid_run();
        logic [12:0] obs;
        div_wr = 1'b1; div_wdata = 8'd9;
        tick();                                    // E+31
        div_wr = 1'b0;
        checks++;
        if ({div_pend, micclk, div_cur} !== {2'b11, 8'd3}) begin
            errors++;
            $display("FAIL rst_pre got pend=%b clk=%b cur=%0d want 1 1 3", div_pend, micclk, div_cur);
        end
        rst = 1'b1; en = 1'b0;
        tick();                                    // E+32
        obs = {micclk, rise_stb, fall_stb, data_valid, div_pend, div_cur};
        checks++;
        if (obs !== {5'b00000, 8'h03}) begin
            errors++;
            $display("FAIL rst_mid_run got=%h want=%h", obs, {5'b00000, 8'h03});
        end
        rst = 1'b0;
        for (int i = 0; i < 6; i++) begin
            tick();
            obs = {micclk, rise_stb, fall_stb, data_valid, div_pend, div_cur};
            checks++;
            if (obs !== {5'b00000, 8'h03}) begin
                errors++;
                $display("FAIL rst_after i=%0d got=%h want=%h", i, obs, {5'b00000, 8'h03});
            end
        end
    endtask

    initial begin
        test_reset();
        test_case_a();
        test_div_change();
        test_stop_high();
        test_clk2();
        test_wake_abort();
        test_reset_mid_run();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
